// File: rtl/ifmux_nport_pkg.sv
// Shared definitions for the N-port ingress frame multiplexer: pointer layout,
// FSM encoding and pointer decode helpers.
package ifmux_nport_pkg;

   localparam int PTR_W    = 20;
   localparam int DEST_LSB = 16;
   localparam int DEST_W   = 4;
   localparam int ERR_LSB  = 13;
   localparam int ERR_W    = 3;
   localparam int TAIL_BIT = 12;
   localparam int LEN_LSB  = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PTR_RD,
      S_PTR_CAP,
      S_DATA,
      S_FLUSH,
      S_PTR_WR
   } state_t;

   function automatic logic ptr_err_flags(input logic [PTR_W-1:0] ptr);
      return |ptr[ERR_LSB +: ERR_W];
   endfunction

endpackage

// File: rtl/ifmux_nport_arb.sv
// Combinational port arbiter: round-robin search from rr_ptr with wrap, or
// strict priority where the lowest requesting index wins.
module rr_arbiter_ppe
   import ifmux_nport_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   localparam int PW        = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PW-1:0]        rr_ptr,
   input  logic                 mode,
   output logic [NUM_PORTS-1:0] gnt_oh,
   output logic [PW-1:0]        gnt_bin
);

   int   idx;
   logic found;

   always_comb begin
      gnt_oh  = '0;
      gnt_bin = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = mode ? i : int'(rr_ptr) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!found && req[idx]) begin
            found       = 1'b1;
            gnt_oh[idx] = 1'b1;
            gnt_bin     = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/ifmux_nport.sv
// Multiplexes frames from NUM_PORTS ingress pointer/data FIFO pairs into one
// output data FIFO plus pointer FIFO, one whole frame at a time.
module ifmux_nport
   import ifmux_nport_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DW        = 8,
   parameter int LENW      = 12,
   parameter int MAX_BEATS = 1536/(DW/8),
   parameter int FREEW     = 13
) (
   input  logic                          clk_sys,
   input  logic                          rst_sys,
   input  logic [NUM_PORTS-1:0]          rx_ptr_fifo_empty,
   output logic [NUM_PORTS-1:0]          rx_ptr_fifo_rd,
   input  logic [NUM_PORTS*20-1:0]       rx_ptr_fifo_dout,
   output logic [NUM_PORTS-1:0]          rx_data_fifo_rd,
   input  logic [NUM_PORTS*DW-1:0]       rx_data_fifo_dout,
   output logic                          sfifo_wr,
   output logic [DW-1:0]                 sfifo_din,
   input  logic [FREEW-1:0]              sfifo_free,
   output logic                          ptr_sfifo_wr,
   output logic [4+NUM_PORTS+LENW-1:0]   ptr_sfifo_din,
   input  logic                          ptr_sfifo_full,
   input  logic [NUM_PORTS-1:0]          port_en,
   input  logic                          prio_mode,
   output logic                          drop_pulse,
   output logic                          busy
);

   localparam int PW  = $clog2(NUM_PORTS);
   localparam int BPW = DW/8;
   localparam int BSH = $clog2(BPW);
   localparam int OW  = 4 + NUM_PORTS + LENW;
   localparam logic [FREEW-1:0] MAX_FREE  = FREEW'(MAX_BEATS);
   localparam logic [31:0]      MAX_BYTES = 32'(MAX_BEATS*BPW);

   state_t                state_q, state_d;
   logic [NUM_PORTS-1:0]  gnt_oh_q, gnt_oh_d;
   logic [PW-1:0]         gnt_bin_q, gnt_bin_d;
   logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
   logic                  bp_q, bp_d;
   logic                  err_q, err_d;
   logic [DEST_W-1:0]     dest_q, dest_d;
   logic [LENW-1:0]       len_q, len_d;
   logic [LENW-1:0]       cnt_q, cnt_d;
   logic                  dvld_q, dvld_d;
   logic [NUM_PORTS-1:0]  rx_ptr_fifo_rd_q, rx_ptr_fifo_rd_d;
   logic [NUM_PORTS-1:0]  rx_data_fifo_rd_q, rx_data_fifo_rd_d;
   logic                  sfifo_wr_q, sfifo_wr_d;
   logic [DW-1:0]         sfifo_din_q, sfifo_din_d;
   logic                  ptr_sfifo_wr_q, ptr_sfifo_wr_d;
   logic [OW-1:0]         ptr_sfifo_din_q, ptr_sfifo_din_d;
   logic                  drop_pulse_q, drop_pulse_d;

   logic [NUM_PORTS-1:0]  eligible, arb_oh;
   logic [PW-1:0]         arb_bin;
   logic [PTR_W-1:0]      cur_ptr;
   logic [DW-1:0]         cur_data;
   logic [LENW-1:0]       cap_len, cap_beats;
   logic                  cap_err;
   logic                  unused_ptr_bits;

   assign eligible = ~rx_ptr_fifo_empty & port_en;

   rr_arbiter_ppe #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .req     (eligible),
      .rr_ptr  (rr_ptr_q),
      .mode    (prio_mode),
      .gnt_oh  (arb_oh),
      .gnt_bin (arb_bin)
   );

   assign cur_ptr   = rx_ptr_fifo_dout[gnt_bin_q*PTR_W +: PTR_W];
   assign cur_data  = rx_data_fifo_dout[gnt_bin_q*DW +: DW];
   assign cap_len   = cur_ptr[LEN_LSB +: LENW];
   assign cap_beats = LENW'(({1'b0, cap_len} + (LENW+1)'(BPW-1)) >> BSH);
   // Oversize frames are not truncated; they are read out and discarded.
   assign cap_err   = ptr_err_flags(cur_ptr) || (cap_len == '0) ||
                      (32'(cap_len) > MAX_BYTES);
   assign unused_ptr_bits = ^cur_ptr[TAIL_BIT:LENW];

   always_comb begin
      state_d           = state_q;
      gnt_oh_d          = gnt_oh_q;
      gnt_bin_d         = gnt_bin_q;
      rr_ptr_d          = rr_ptr_q;
      err_d             = err_q;
      dest_d            = dest_q;
      len_d             = len_q;
      cnt_d             = cnt_q;
      bp_d              = (sfifo_free < MAX_FREE) || ptr_sfifo_full;
      dvld_d            = |rx_data_fifo_rd_q;
      rx_ptr_fifo_rd_d  = '0;
      rx_data_fifo_rd_d = '0;
      sfifo_wr_d        = dvld_q && !err_q;
      sfifo_din_d       = dvld_q ? cur_data : sfifo_din_q;
      ptr_sfifo_wr_d    = 1'b0;
      ptr_sfifo_din_d   = ptr_sfifo_din_q;
      drop_pulse_d      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if ((|eligible) && !bp_q) begin
               state_d          = S_PTR_RD;
               gnt_oh_d         = arb_oh;
               gnt_bin_d        = arb_bin;
               rx_ptr_fifo_rd_d = arb_oh;
               if (!prio_mode)
                  rr_ptr_d = (arb_bin == PW'(NUM_PORTS-1)) ? '0 : arb_bin + 1'b1;
            end
         end
         S_PTR_RD: state_d = S_PTR_CAP;
         S_PTR_CAP: begin
            dest_d = cur_ptr[DEST_LSB +: DEST_W];
            len_d  = cap_len;
            err_d  = cap_err;
            if (cap_len == '0) begin
               state_d      = S_PTR_WR;
               drop_pulse_d = 1'b1;
            end else begin
               state_d           = S_DATA;
               rx_data_fifo_rd_d = gnt_oh_q;
               cnt_d             = cap_beats - 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               state_d = S_FLUSH;
            end else begin
               rx_data_fifo_rd_d = gnt_oh_q;
               cnt_d             = cnt_q - 1'b1;
            end
         end
         // dvld_q low means the final word is on sfifo_wr this cycle.
         S_FLUSH: begin
            if (!dvld_q) begin
               state_d = S_PTR_WR;
               if (err_q) begin
                  drop_pulse_d = 1'b1;
               end else begin
                  ptr_sfifo_wr_d  = 1'b1;
                  ptr_sfifo_din_d = {dest_q, gnt_oh_q, len_q};
               end
            end
         end
         S_PTR_WR: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         state_q           <= S_IDLE;
         gnt_oh_q          <= '0;
         gnt_bin_q         <= '0;
         rr_ptr_q          <= '0;
         bp_q              <= 1'b1;
         err_q             <= 1'b0;
         dest_q            <= '0;
         len_q             <= '0;
         cnt_q             <= '0;
         dvld_q            <= 1'b0;
         rx_ptr_fifo_rd_q  <= '0;
         rx_data_fifo_rd_q <= '0;
         sfifo_wr_q        <= 1'b0;
         sfifo_din_q       <= '0;
         ptr_sfifo_wr_q    <= 1'b0;
         ptr_sfifo_din_q   <= '0;
         drop_pulse_q      <= 1'b0;
      end else begin
         state_q           <= state_d;
         gnt_oh_q          <= gnt_oh_d;
         gnt_bin_q         <= gnt_bin_d;
         rr_ptr_q          <= rr_ptr_d;
         bp_q              <= bp_d;
         err_q             <= err_d;
         dest_q            <= dest_d;
         len_q             <= len_d;
         cnt_q             <= cnt_d;
         dvld_q            <= dvld_d;
         rx_ptr_fifo_rd_q  <= rx_ptr_fifo_rd_d;
         rx_data_fifo_rd_q <= rx_data_fifo_rd_d;
         sfifo_wr_q        <= sfifo_wr_d;
         sfifo_din_q       <= sfifo_din_d;
         ptr_sfifo_wr_q    <= ptr_sfifo_wr_d;
         ptr_sfifo_din_q   <= ptr_sfifo_din_d;
         drop_pulse_q      <= drop_pulse_d;
      end
   end

   assign rx_ptr_fifo_rd  = rx_ptr_fifo_rd_q;
   assign rx_data_fifo_rd = rx_data_fifo_rd_q;
   assign sfifo_wr        = sfifo_wr_q;
   assign sfifo_din       = sfifo_din_q;
   assign ptr_sfifo_wr    = ptr_sfifo_wr_q;
   assign ptr_sfifo_din   = ptr_sfifo_din_q;
   assign drop_pulse      = drop_pulse_q;
   assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_ifmux_nport.sv
// Directed bench for ifmux_nport: an 8-bit and a 32-bit instance fed by
// behavioural 1-cycle-latency source FIFOs, checked against hand-computed values.
module tb_ifmux_nport;

   localparam int NP = 4, LENW = 12, FREEW = 13, OW = 4 + NP + LENW;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic rst_sys, psf_full, prio_mode;
   logic [NP-1:0] port_en;
   logic [FREEW-1:0] sf_free;

   logic [NP-1:0] ptr_empty, ptr_rd, data_rd;
   logic [NP-1:0][19:0] ptr_dout = '0;
   logic [NP-1:0][7:0]  data_dout = '0;
   logic sf_wr, psf_wr, drop, busy;
   logic [7:0] sf_din;
   logic [OW-1:0] psf_din;

   logic [NP-1:0] ptr_empty32, ptr_rd32, data_rd32;
   logic [NP-1:0][19:0] ptr_dout32 = '0;
   logic [NP-1:0][31:0] data_dout32 = '0;
   logic sf_wr32, psf_wr32, drop32, busy32;
   logic [31:0] sf_din32;
   logic [OW-1:0] psf_din32;

   ifmux_nport #(.NUM_PORTS(NP), .DW(8)) u8 (
      .clk_sys(clk_sys), .rst_sys(rst_sys),
      .rx_ptr_fifo_empty(ptr_empty), .rx_ptr_fifo_rd(ptr_rd), .rx_ptr_fifo_dout(ptr_dout),
      .rx_data_fifo_rd(data_rd), .rx_data_fifo_dout(data_dout),
      .sfifo_wr(sf_wr), .sfifo_din(sf_din), .sfifo_free(sf_free),
      .ptr_sfifo_wr(psf_wr), .ptr_sfifo_din(psf_din), .ptr_sfifo_full(psf_full),
      .port_en(port_en), .prio_mode(prio_mode), .drop_pulse(drop), .busy(busy));

   ifmux_nport #(.NUM_PORTS(NP), .DW(32)) u32 (
      .clk_sys(clk_sys), .rst_sys(rst_sys),
      .rx_ptr_fifo_empty(ptr_empty32), .rx_ptr_fifo_rd(ptr_rd32), .rx_ptr_fifo_dout(ptr_dout32),
      .rx_data_fifo_rd(data_rd32), .rx_data_fifo_dout(data_dout32),
      .sfifo_wr(sf_wr32), .sfifo_din(sf_din32), .sfifo_free(sf_free),
      .ptr_sfifo_wr(psf_wr32), .ptr_sfifo_din(psf_din32), .ptr_sfifo_full(psf_full),
      .port_en(port_en), .prio_mode(prio_mode), .drop_pulse(drop32), .busy(busy32));

   // Source FIFO models: pointer storage written by tasks, read pointers by the model.
   logic [19:0] pmem [NP][64];
   logic [19:0] pmem32 [64];
   int pwr[NP] = '{0, 0, 0, 0};
   int prd[NP] = '{0, 0, 0, 0};
   int dseq[NP] = '{0, 0, 0, 0};
   int pwr32 = 0, prd32 = 0, dseq32 = 0;

   function automatic logic [7:0] dword8(input int p, input int s);
      return 8'((p << 6) ^ s);
   endfunction

   function automatic logic [31:0] dword32(input int s);
      return 32'h1000_0000 + 32'(s);
   endfunction

   function automatic logic [19:0] mkptr(input logic [3:0] dest, input logic [2:0] ef,
                                         input int len);
      logic [11:0] l;
      l = 12'(len);
      return {dest, ef, 1'b1, l};
   endfunction

   always_comb begin
      for (int p = 0; p < NP; p++) ptr_empty[p] = (prd[p] == pwr[p]);
      ptr_empty32 = {3'b111, prd32 == pwr32};
   end

   always @(posedge clk_sys) begin
      for (int p = 0; p < NP; p++) begin
         if (ptr_rd[p]) begin
            ptr_dout[p] <= pmem[p][prd[p] % 64];
            prd[p]      <= prd[p] + 1;
         end
         if (data_rd[p]) begin
            data_dout[p] <= dword8(p, dseq[p]);
            dseq[p]      <= dseq[p] + 1;
         end
      end
      if (ptr_rd32[0]) begin
         ptr_dout32[0] <= pmem32[prd32 % 64];
         prd32         <= prd32 + 1;
      end
      if (data_rd32[0]) begin
         data_dout32[0] <= dword32(dseq32);
         dseq32         <= dseq32 + 1;
      end
   end

   // Output monitor, sampled on the falling edge.
   int cyc = 0, wcnt = 0, pcnt = 0, drops = 0, gcnt = 0, last_wr_cyc = 0, last_pw_cyc = 0;
   int drd[NP] = '{0, 0, 0, 0};
   int wcnt32 = 0, pcnt32 = 0, rd32 = 0;
   logic [7:0]    wbuf [4096];
   logic [31:0]   wbuf32 [64];
   logic [OW-1:0] pbuf [64];
   logic [OW-1:0] plast32 = '0;
   int gbuf [64];

   always @(negedge clk_sys) begin
      cyc <= cyc + 1;
      if (sf_wr) begin
         wbuf[wcnt % 4096] <= sf_din;
         wcnt <= wcnt + 1;
         last_wr_cyc <= cyc;
      end
      if (psf_wr) begin
         pbuf[pcnt % 64] <= psf_din;
         pcnt <= pcnt + 1;
         last_pw_cyc <= cyc;
      end
      if (drop) drops <= drops + 1;
      for (int p = 0; p < NP; p++) begin
         if (data_rd[p]) drd[p] <= drd[p] + 1;
         if (ptr_rd[p]) gbuf[gcnt % 64] <= p;
      end
      if (|ptr_rd) gcnt <= gcnt + 1;
      if (sf_wr32) begin
         wbuf32[wcnt32 % 64] <= sf_din32;
         wcnt32 <= wcnt32 + 1;
      end
      if (psf_wr32) begin
         plast32 <= psf_din32;
         pcnt32 <= pcnt32 + 1;
      end
      if (data_rd32[0]) rd32 <= rd32 + 1;
   end

   int checks = 0, errors = 0;

   task automatic load8(input int p, input logic [19:0] ptr);
      pmem[p][pwr[p] % 64] = ptr;
      pwr[p] = pwr[p] + 1;
   endtask

   task automatic wait_idle(input int maxc);
      int k;
      k = 0;
      do begin
         @(negedge clk_sys);
         k++;
      end while ((busy || ptr_empty != 4'hF) && k < maxc);
      repeat (2) @(negedge clk_sys);
      checks++;
      if (busy || ptr_empty != 4'hF) begin
         errors++;
         $display("FAIL wait_idle timeout busy=%b empty=%b exp busy=0 empty=1111", busy, ptr_empty);
      end
   endtask

   task automatic test_reset();
      rst_sys = 1'b1;
      repeat (3) @(negedge clk_sys);
      checks++;
      if ({ptr_rd, data_rd, sf_wr, psf_wr, drop, busy} !== '0) begin
         errors++;
         $display("FAIL reset_strobes got=%b exp=0", {ptr_rd, data_rd, sf_wr, psf_wr, drop, busy});
      end
      checks++;
      if (sf_din !== 8'h00 || psf_din !== '0) begin
         errors++;
         $display("FAIL reset_din got sf=%h ptr=%h exp 0", sf_din, psf_din);
      end
      checks++;
      if ({ptr_rd32, data_rd32, sf_wr32, psf_wr32, drop32, busy32, sf_din32} !== '0) begin
         errors++;
         $display("FAIL reset_u32 got busy=%b sf_din=%h exp 0", busy32, sf_din32);
      end
   endtask

   task automatic test_single_frame();
      int w0, p0, d0, s0, dr0, bad;
      load8(1, mkptr(4'hA, 3'b000, 64));
      w0 = wcnt; p0 = pcnt; d0 = drops; s0 = dseq[1]; dr0 = drd[1];
      rst_sys = 1'b0;
      @(negedge clk_sys);
      checks++;
      if (ptr_rd !== 4'b0000) begin
         errors++;
         $display("FAIL bp_after_reset ptr_rd got=%b exp=0000", ptr_rd);
      end
      @(negedge clk_sys);
      checks++;
      if (ptr_rd !== 4'b0010) begin
         errors++;
         $display("FAIL first_grant ptr_rd got=%b exp=0010", ptr_rd);
      end
      wait_idle(300);
      checks++;
      if (wcnt - w0 != 64) begin
         errors++;
         $display("FAIL single_wr_count got=%0d exp=64", wcnt - w0);
      end
      bad = 0;
      for (int i = 0; i < 64; i++) if (wbuf[(w0 + i) % 4096] !== dword8(1, s0 + i)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL single_data_order bad_words got=%0d exp=0", bad);
      end
      checks++;
      if (pcnt - p0 != 1 || pbuf[p0 % 64] !== {4'hA, 4'b0010, 12'd64}) begin
         errors++;
         $display("FAIL single_ptr got n=%0d din=%h exp n=1 din=%h", pcnt - p0,
                  pbuf[p0 % 64], {4'hA, 4'b0010, 12'd64});
      end
      checks++;
      if (last_pw_cyc <= last_wr_cyc) begin
         errors++;
         $display("FAIL ptr_after_data got ptr_cyc=%0d last_data_cyc=%0d exp later", last_pw_cyc, last_wr_cyc);
      end
      checks++;
      if (drd[1] - dr0 != 64 || drops != d0) begin
         errors++;
         $display("FAIL single_reads got rd=%0d drops=%0d exp rd=64 drops=0", drd[1] - dr0, drops - d0);
      end
   endtask

   task automatic run_order(input logic mode, input logic [31:0] exp_seq);
      int g0, p0;
      logic [31:0] got;
      prio_mode = mode;
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < NP; p++) load8(p, mkptr(4'(p), 3'b000, 4));
      g0 = gcnt; p0 = pcnt;
      rst_sys = 1'b0;
      wait_idle(400);
      got = '0;
      for (int i = 0; i < 8; i++) got[4*i +: 4] = 4'(gbuf[(g0 + i) % 64]);
      checks++;
      if (gcnt - g0 != 8 || got !== exp_seq) begin
         errors++;
         $display("FAIL grant_order mode=%0d got n=%0d seq=%h exp n=8 seq=%h", mode, gcnt - g0, got, exp_seq);
      end
      checks++;
      if (pcnt - p0 != 8) begin
         errors++;
         $display("FAIL order_ptr_writes mode=%0d got=%0d exp=8", mode, pcnt - p0);
      end
      prio_mode = 1'b0;
   endtask

   task automatic test_round_robin();
      rst_sys = 1'b1;
      @(negedge clk_sys);
      run_order(1'b0, 32'h3210_3210);
   endtask

   task automatic test_strict();
      run_order(1'b1, 32'h3322_1100);
   endtask

   task automatic drop_case(input string nm, input int p, input logic [2:0] ef, input int len,
                            input int exp_rd, input int exp_wr, input int exp_pw, input int exp_drop);
      int w0, p0, d0, r0;
      w0 = wcnt; p0 = pcnt; d0 = drops; r0 = drd[p];
      load8(p, mkptr(4'h1, ef, len));
      wait_idle(2000);
      checks++;
      if (drd[p] - r0 != exp_rd) begin
         errors++;
         $display("FAIL %s data_reads got=%0d exp=%0d", nm, drd[p] - r0, exp_rd);
      end
      checks++;
      if (wcnt - w0 != exp_wr || pcnt - p0 != exp_pw || drops - d0 != exp_drop) begin
         errors++;
         $display("FAIL %s outputs got wr=%0d ptr=%0d drop=%0d exp wr=%0d ptr=%0d drop=%0d",
                  nm, wcnt - w0, pcnt - p0, drops - d0, exp_wr, exp_pw, exp_drop);
      end
   endtask

   task automatic test_error_drop();
      drop_case("err_flag",  2, 3'b010, 100,  100,  0,    0, 1);
      drop_case("zero_len",  3, 3'b000, 0,    0,    0,    0, 1);
      drop_case("oversize",  0, 3'b000, 1537, 1537, 0,    0, 1);
      drop_case("max_size",  0, 3'b000, 1536, 1536, 1536, 1, 0);
   endtask

   task automatic test_backpressure();
      int g0, w0, p0, k;
      sf_free = 13'd1535;
      @(negedge clk_sys);
      g0 = gcnt; w0 = wcnt; p0 = pcnt;
      load8(0, mkptr(4'h5, 3'b000, 20));
      repeat (8) @(negedge clk_sys);
      checks++;
      if (gcnt != g0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_hold got grants=%0d busy=%b exp grants=0 busy=0", gcnt - g0, busy);
      end
      sf_free = 13'd1536;
      k = 0;
      do begin
         @(negedge clk_sys);
         k++;
      end while (ptr_rd == '0 && k < 6);
      checks++;
      if (k > 2 || ptr_rd !== 4'b0001) begin
         errors++;
         $display("FAIL bp_release got cycles=%0d ptr_rd=%b exp cycles<=2 ptr_rd=0001", k, ptr_rd);
      end
      repeat (6) @(negedge clk_sys);
      psf_full = 1'b1;
      repeat (40) @(negedge clk_sys);
      checks++;
      if (busy !== 1'b0 || pcnt - p0 != 1 || wcnt - w0 != 20) begin
         errors++;
         $display("FAIL full_midframe got busy=%b ptr=%0d wr=%0d exp busy=0 ptr=1 wr=20",
                  busy, pcnt - p0, wcnt - w0);
      end
      psf_full = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic test_reset_mid_frame();
      int r0, w0, p0, k;
      r0 = drd[3];
      load8(3, mkptr(4'h2, 3'b000, 64));
      k = 0;
      do begin
         @(negedge clk_sys);
         k++;
      end while (drd[3] - r0 < 10 && k < 60);
      checks++;
      if (drd[3] - r0 < 10) begin
         errors++;
         $display("FAIL mid_reach_beat10 got=%0d exp>=10", drd[3] - r0);
      end
      rst_sys = 1'b1;
      @(negedge clk_sys);
      checks++;
      if ({ptr_rd, data_rd, sf_wr, psf_wr, drop, busy} !== '0) begin
         errors++;
         $display("FAIL mid_reset_strobes got=%b exp=0", {ptr_rd, data_rd, sf_wr, psf_wr, drop, busy});
      end
      rst_sys = 1'b0;
      w0 = wcnt; p0 = pcnt;
      repeat (10) @(negedge clk_sys);
      checks++;
      if (wcnt != w0 || pcnt != p0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_quiet got wr=%0d ptr=%0d busy=%b exp 0 0 0", wcnt - w0, pcnt - p0, busy);
      end
   endtask

   task automatic test_dw32();
      int r0, w0, p0, s0, k, bad;
      r0 = rd32; w0 = wcnt32; p0 = pcnt32; s0 = dseq32;
      pmem32[pwr32 % 64] = mkptr(4'h3, 3'b000, 61);
      pwr32 = pwr32 + 1;
      k = 0;
      do begin
         @(negedge clk_sys);
         k++;
      end while ((busy32 || prd32 != pwr32) && k < 200);
      repeat (2) @(negedge clk_sys);
      checks++;
      if (rd32 - r0 != 16 || wcnt32 - w0 != 16) begin
         errors++;
         $display("FAIL dw32_beats got rd=%0d wr=%0d exp 16 16", rd32 - r0, wcnt32 - w0);
      end
      checks++;
      if (pcnt32 - p0 != 1 || plast32 !== {4'h3, 4'b0001, 12'd61}) begin
         errors++;
         $display("FAIL dw32_ptr got n=%0d din=%h exp n=1 din=%h", pcnt32 - p0, plast32,
                  {4'h3, 4'b0001, 12'd61});
      end
      bad = 0;
      for (int i = 0; i < 16; i++) if (wbuf32[(w0 + i) % 64] !== dword32(s0 + i)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL dw32_data_order bad_words got=%0d exp=0", bad);
      end
   endtask

   initial begin
      rst_sys   = 1'b1;
      psf_full  = 1'b0;
      prio_mode = 1'b0;
      port_en   = 4'hF;
      sf_free   = 13'd1600;
      test_reset();
      test_single_frame();
      test_round_robin();
      test_strict();
      test_error_drop();
      test_backpressure();
      test_reset_mid_frame();
      test_dw32();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
